// File: rtl/serial_msg_arbiter.sv
// serial_msg_arbiter
// Shares one 32-bit put channel into the serial bridge among NUM_CHANNELS
// requesters. Each granted packet goes out as one framing header word
// {HDR_MAGIC, 4'h0, chan, 8'h00, len} followed by len payload words taken
// straight from the owner. A packet is never preempted once granted.
// Build option: define SERIAL_ARB_FIXED_PRIO_EN to pick the lowest-index
// requester instead of rotating round-robin (rr_ptr then stays at 0).
module serial_msg_arbiter #(
  parameter int         NUM_CHANNELS = 4,
  parameter logic [7:0] HDR_MAGIC    = 8'hA5
) (
  input  logic                       sys_clk_pin,
  input  logic                       sys_rst_pin,
  input  logic [NUM_CHANNELS-1:0]    req_valid,
  input  logic [8*NUM_CHANNELS-1:0]  req_len,
  input  logic [32*NUM_CHANNELS-1:0] req_data,
  output logic [NUM_CHANNELS-1:0]    req_ready,
  output logic [NUM_CHANNELS-1:0]    grant,
  input  logic                       feeder_put_rdy,
  output logic                       feeder_put_en,
  output logic [31:0]                feeder_put_data,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_CHANNELS-1:0] r_grant;
  logic [3:0]              r_chan;
  logic [3:0]              r_rr_ptr;
  logic [7:0]              r_len;
  logic [7:0]              r_count;

  logic                    w_found;
  logic [3:0]              w_win;
  logic [NUM_CHANNELS-1:0] w_win_oh;
  logic [7:0]              w_win_len;
  logic [31:0]             w_owner_data;
  logic                    w_owner_valid;
  logic                    w_hdr_xfer;
  logic                    w_pay_xfer;

  // Winner search: first requester at or above rr_ptr, else wrap to the lowest.
  // With rr_ptr pinned at 0 this is plain lowest-index priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!w_found && req_valid[j] && (j >= int'(r_rr_ptr))) begin
        w_found = 1'b1;
        w_win   = 4'(j);
      end
    end
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_win   = 4'(j);
      end
    end
  end

  // Per-channel muxes: winner's length/one-hot, and the current owner's word.
  always_comb begin
    w_win_oh      = '0;
    w_win_len     = '0;
    w_owner_data  = '0;
    w_owner_valid = 1'b0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      w_win_oh[j] = (w_win == 4'(j));
      if (w_win == 4'(j)) w_win_len = req_len[8*j +: 8];
      if (r_grant[j]) begin
        w_owner_data  = req_data[32*j +: 32];
        w_owner_valid = req_valid[j];
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next state and bus-side outputs; nothing is driven outside HEADER/PAYLOAD.
  always_comb begin
    w_state_nxt     = r_state;
    feeder_put_en   = 1'b0;
    feeder_put_data = '0;
    req_ready       = '0;
    w_hdr_xfer      = 1'b0;
    w_pay_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        feeder_put_data = {HDR_MAGIC, 4'h0, r_chan, 8'h00, r_len};
        w_hdr_xfer      = feeder_put_rdy;
        feeder_put_en   = w_hdr_xfer;
        if (w_hdr_xfer) w_state_nxt = (r_len == 8'd0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        feeder_put_data = w_owner_data;
        w_pay_xfer      = w_owner_valid & feeder_put_rdy;
        feeder_put_en   = w_pay_xfer;
        req_ready       = r_grant & {NUM_CHANNELS{w_pay_xfer}};
        if (w_pay_xfer && (r_count == 8'd1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, packet length/remaining count and the rotation pointer.
  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      r_grant  <= '0;
      r_chan   <= '0;
      r_len    <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_win_oh;
            r_chan  <= w_win;
            r_len   <= w_win_len;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`else
            r_rr_ptr <= (w_win == 4'(NUM_CHANNELS - 1)) ? 4'd0 : (w_win + 4'd1);
`endif
          end
        end
        S_HEADER: begin
          if (w_hdr_xfer) begin
            if (r_len == 8'd0) r_grant <= '0;
            else               r_count <= r_len;
          end
        end
        S_PAYLOAD: begin
          if (w_pay_xfer) begin
            r_count <= r_count - 8'd1;
            if (r_count == 8'd1) r_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_msg_arbiter.sv
// tb_serial_msg_arbiter
// Randomised channel drivers plus a packet-level reference model: each grant
// is predicted from the requesters visible at the decision edge, and every bus
// word is compared against a queue holding the expected header and payload.
`timescale 1ns/1ps
module tb_serial_msg_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_len;
  logic [32*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           put_rdy;
  logic           put_en;
  logic [31:0]    put_data;
  logic           busy;

  serial_msg_arbiter #(.NUM_CHANNELS(N), .HDR_MAGIC(8'hA5)) dut (
    .sys_clk_pin     (clk),
    .sys_rst_pin     (rst_n),
    .req_valid       (req_valid),
    .req_len         (req_len),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .grant           (grant),
    .feeder_put_rdy  (put_rdy),
    .feeder_put_en   (put_en),
    .feeder_put_data (put_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Channel driver state
  int          pend[N];
  int          plen[N];
  int          widx[N];
  int          gap[N];
  logic [31:0] pdat[N][256];
  int          rdy_pct = 100;
  int          bub_pct = 0;
  int          gap_max = 0;
  int          regen_len = 1;
  logic [N-1:0] regen_mask = '0;

  // Reference model state
  logic [31:0] exp_q[$];
  int          m_ptr = 0;
  int          m_owner = -1;
  bit          m_hdr = 1'b0;
  logic        prev_busy = 1'b0;
  logic [N-1:0] seen_valid = '0;
  int          hdr_log[$];
  logic [31:0] last_hdr = '0;
  int          n_ready[N];
  int          n_grant[N];
  int          cyc = 0;
  int          first_x = -1;
  int          last_x = -1;
  int          pkts_done = 0;

  function automatic int next_len();
    if (regen_len >= 0) return regen_len;
    return ($urandom_range(39) == 0) ? 255 : int'($urandom_range(7));
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    int w;
    w = -1;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (w < 0 && v[k]) w = k;
`else
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && v[c]) w = c;
    end
`endif
    return w;
  endfunction

  function automatic bit any_pend();
    bit a;
    a = 1'b0;
    for (int c = 0; c < N; c++) if (pend[c] != 0) a = 1'b1;
    return a;
  endfunction

  task automatic new_packet(input int ch, input int len);
    pend[ch] = 1;
    plen[ch] = len;
    widx[ch] = 0;
    gap[ch]  = -1;
    for (int i = 0; i < 256; i++) pdat[ch][i] = $urandom;
  endtask

  task automatic stop_regen();
    regen_mask = '0;
    for (int c = 0; c < N; c++) gap[c] = -1;
  endtask

  task automatic clear_stats();
    hdr_log.delete();
    for (int c = 0; c < N; c++) begin
      n_ready[c] = 0;
      n_grant[c] = 0;
    end
    first_x = -1;
    last_x  = -1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_owner    = -1;
    m_ptr      = 0;
    m_hdr      = 1'b0;
    prev_busy  = 1'b0;
    seen_valid = '0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 0;
      plen[c] = 0;
      widx[c] = 0;
      gap[c]  = -1;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      req_len[8*c +: 8]   = 8'(plen[c]);
      req_data[32*c +: 32] = pdat[c][(widx[c] > 255) ? 255 : widx[c]];
      if (pend[c] == 0)   req_valid[c] = 1'b0;
      else if (grant[c])  req_valid[c] = ($urandom_range(99) >= bub_pct);
      else                req_valid[c] = 1'b1;
    end
    put_rdy = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic monitor();
    int w;
    cyc++;
    if (busy && !prev_busy) begin
      w = pick(seen_valid);
      if (w < 0) begin
        chk("grant_without_request", 32'(grant), 32'd0);
      end else begin
        chk("grant_winner", 32'(grant), 32'(1 << w));
        m_owner = w;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
        hdr_log.push_back(w);
        exp_q.push_back({8'hA5, 4'h0, 4'(w), 8'h00, 8'(plen[w])});
        for (int i = 0; i < plen[w]; i++) exp_q.push_back(pdat[w][i]);
        m_hdr = 1'b1;
      end
    end
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
    for (int c = 0; c < N; c++) begin
      if (grant[c])     n_grant[c]++;
      if (req_ready[c]) n_ready[c]++;
    end
    if (put_en) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      chk("en_with_rdy_low", 32'(put_rdy), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        if (m_hdr) begin
          chk("header_word", put_data, exp_q.pop_front());
          chk("req_ready_hdr", 32'(req_ready), 32'd0);
          last_hdr = put_data;
        end else begin
          chk("payload_word", put_data, exp_q.pop_front());
          chk("req_ready_pay", 32'(req_ready), 32'(1 << m_owner));
          widx[m_owner]++;
        end
        m_hdr = 1'b0;
        if (exp_q.size() == 0) begin
          pend[m_owner] = 0;
          gap[m_owner]  = regen_mask[m_owner] ? int'($urandom_range(gap_max)) : -1;
          m_owner = -1;
          pkts_done++;
        end
      end
    end else begin
      chk("req_ready_no_xfer", 32'(req_ready), 32'd0);
    end
    if (!busy) chk("idle_data", put_data, 32'd0);
    prev_busy  = busy;
    seen_valid = req_valid;
  endtask

  // One clock: drive on the falling edge, observe just before the rising edge.
  task automatic step();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      if (pend[c] == 0 && gap[c] >= 0) begin
        if (gap[c] == 0) new_packet(c, next_len());
        else             gap[c]--;
      end
    end
    drive();
    #4;
    monitor();
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((any_pend() || m_owner >= 0 || busy) && k < max) begin
      step();
      k++;
    end
    chk("drain_in_time", 32'(k < max), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int post;
    int ones;
    rst_n     = 1'b0;
    req_valid = '0;
    req_len   = '0;
    req_data  = '0;
    put_rdy   = 1'b0;
    model_reset();
    clear_stats();

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_en",    32'(put_en),    32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data",  put_data,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Single packet, channel 1, len 3, bridge always ready
    rdy_pct = 100; bub_pct = 0;
    clear_stats();
    post = cyc;
    new_packet(1, 3);
    repeat (10) step();
    chk("t1_header",      last_hdr,                  32'hA5010003);
    chk("t1_latency",     32'(first_x - post),       32'd2);
    chk("t1_consecutive", 32'(last_x - first_x),     32'd3);
    chk("t1_ready_pulses", 32'(n_ready[1]),          32'd3);
    chk("t1_busy_end",    32'(busy),                 32'd0);

    // Simultaneous requests from reset: 0 then 2, then again 0 then 2
    apply_reset();
    clear_stats();
    new_packet(0, 1); new_packet(2, 1);
    drain(100);
    new_packet(0, 1); new_packet(2, 1);
    drain(100);
    chk("t2_count", 32'(hdr_log.size()), 32'd4);
    chk("t2_order0", 32'(hdr_log[0]), 32'd0);
    chk("t2_order1", 32'(hdr_log[1]), 32'd2);
    chk("t2_order2", 32'(hdr_log[2]), 32'd0);
    chk("t2_order3", 32'(hdr_log[3]), 32'd2);

    // All four continuously requesting
    apply_reset();
    clear_stats();
    regen_len = 1; gap_max = 0; regen_mask = '1;
    for (int c = 0; c < N; c++) new_packet(c, 1);
    k = 0;
    while (hdr_log.size() < 5 && k < 200) begin step(); k++; end
    stop_regen();
    chk("t3_enough_grants", 32'(hdr_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
`ifdef SERIAL_ARB_FIXED_PRIO_EN
      chk("t3_order", 32'(hdr_log[i]), 32'd0);
`else
      chk("t3_order", 32'(hdr_log[i]), 32'(i % N));
`endif
    end
    drain(500);

    // Header-only packet
    clear_stats();
    new_packet(3, 0);
    drain(50);
    chk("t4_header",      last_hdr,           32'hA5030000);
    chk("t4_grant_cycles", 32'(n_grant[3]),   32'd1);
    chk("t4_no_ready",    32'(n_ready[3]),    32'd0);

    // Stalling bridge and owner bubbles
    rdy_pct = 50; bub_pct = 40;
    clear_stats();
    new_packet(0, 4);
    drain(300);
    chk("t5_ready_pulses", 32'(n_ready[0]),     32'd4);
    chk("t5_one_packet",   32'(hdr_log.size()), 32'd1);

    // Asynchronous reset in the middle of a payload
    rdy_pct = 100; bub_pct = 0;
    clear_stats();
    new_packet(0, 5);
    k = 0;
    while (widx[0] < 2 && k < 50) begin step(); k++; end
    chk("t6_mid_payload", 32'(widx[0]), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en",    32'(put_en),    32'd0);
    chk("t6_rst_grant", 32'(grant),     32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_data",  put_data,       32'd0);
    model_reset();
    @(negedge clk);
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    new_packet(2, 1);
    drain(50);
    chk("t6_fresh_header", last_hdr,         32'hA5020001);
    chk("t6_fresh_count",  32'(hdr_log.size()), 32'd1);

    // Two channels continuously requesting
    clear_stats();
    regen_len = 1; gap_max = 0; regen_mask = 4'b0011;
    new_packet(0, 1); new_packet(1, 1);
    k = 0;
    while (hdr_log.size() < 6 && k < 300) begin step(); k++; end
    stop_regen();
    ones = 0;
    for (int i = 0; i < 6; i++) if (hdr_log[i] == 1) ones++;
`ifdef SERIAL_ARB_FIXED_PRIO_EN
    chk("t7_ch1_grants", 32'(ones), 32'd0);
`else
    chk("t7_ch1_grants", 32'(ones), 32'd3);
`endif
    drain(500);

    // Random soak
    rdy_pct = 70; bub_pct = 20; gap_max = 3; regen_len = -1; regen_mask = '1;
    pkts_done = 0;
    for (int c = 0; c < N; c++) new_packet(c, next_len());
    repeat (3000) step();
    stop_regen();
    drain(3000);
    chk("soak_progress", 32'(pkts_done > 50), 32'd1);
    chk("soak_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
